// File: rtl/mul_seq_ctrl.sv
// Iterative radix-2 shift-add multiplier sequencer for the EX stage.
// Stalls the pipeline while running and pulses done with the low product bits.
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic             accept;
    logic             last;
    logic             step;

    assign accept = (state == IDLE) && start_i && !flush_i;
    assign step   = (state == RUN) && !flush_i;
    assign last   = (mplier >> 1) == '0;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; flush always returns to IDLE.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (src2_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_n = IDLE;
                end else if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand latch and one shift-add step per RUN cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (accept) begin
            mcand  <= src1_i;
            mplier <= src2_i;
            acc    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign busy_o   = (state == RUN);
    assign done_o   = (state == DONE);
    assign result_o = acc;
    assign stall_o  = !rst_i && !flush_i &&
                      (((state == IDLE) && start_i) || (state == RUN));

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencer for the iterative MUL unit in the EX stage. When the ALU control decode selects MUL, this block latches the operands and runs a radix-2 shift-add multiply, one multiplier bit per cycle. While the multiply is in progress it stalls the pipeline. It then presents the low WIDTH bits of the product for one cycle, when EX is allowed to advance. Multiplication terminates early once the remaining multiplier bits are all zero.

## Interface
- WIDTH, 32, operand and result width in bits.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  EX holds a MUL (ALU control == 4'b1000); sampled only in IDLE.
- src1_i  in  WIDTH  multiplicand (rs).
- src2_i  in  WIDTH  multiplier (rt).
- flush_i  in  1  EX flush (branch taken); abandons any operation in flight.
- stall_o  out  1  freeze PC, IF/ID and ID/EX; combinational.
- busy_o  out  1  state is RUN; registered.
- done_o  out  1  result valid this cycle; EX/MEM captures result_o; registered.
- result_o  out  WIDTH  low WIDTH bits of src1*src2; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE. Internal registers are mcand (WIDTH), mplier (WIDTH) and acc (WIDTH). result_o = acc.

**IDLE**
- If start_i=1 and flush_i=0: mcand<=src1_i, mplier<=src2_i, acc<=0.
- Next state is DONE if src2_i==0, otherwise RUN.
- If start_i=0, or flush_i=1: stay in IDLE; registers unchanged.

**RUN**
- Each cycle: if mplier[0], acc<=acc+mcand (mod 2^WIDTH, carry discarded).
- Each cycle: mcand<=mcand<<1 and mplier<=mplier>>1 (logical shifts).
- Go to DONE when (mplier>>1)==0, i.e. in the same cycle the last set bit is consumed.

**DONE**
- Always go to IDLE next cycle.
- start_i is ignored in DONE; the MUL that started the operation leaves EX at the end of this cycle.

**Outputs**
- stall_o = !rst_i && !flush_i && ((IDLE && start_i) || RUN).
- done_o = (state==DONE).
- Signed and unsigned operands give the same result, since only the low WIDTH bits are kept.

**Flush and reset**
- flush_i in RUN or DONE: go to IDLE, done_o=0 next cycle, acc retained.
- flush_i has priority over start_i.
- rst_i: state<=IDLE; acc, mcand, mplier <= 0. Therefore result_o=0, done_o=0, busy_o=0 and stall_o=0, including when rst_i is asserted mid-RUN.

## Timing
- k is the index of the highest set bit of src2_i.
- Accept cycle = the cycle in which start_i is seen in IDLE. stall_o is high in it.
- Number of RUN cycles = k+1; stall_o stays high through all of them.
- done_o rises in cycle (accept + k + 2), and stall_o is low in that cycle.
- src2_i==0: one stall cycle, then done_o in the next cycle with result 0.
- Worst case (bit WIDTH-1 set): WIDTH+1 stall cycles.
- Back-to-back MULs: the earliest possible accept of the second is the cycle after DONE, i.e. one IDLE cycle between operations.
- The EX-stage operand values presented at accept are the only ones used; later changes on src1_i/src2_i have no effect.

## Test plan
- 3 x 5: start at cycle 0 -> stall_o high in cycles 0-3, busy_o high in 1-3, done_o=1 with result_o=15 in cycle 4.
- 0xFFFFFFFF x 0xFFFFFFFF: 32 RUN cycles, 33 stall cycles -> done_o with result_o=0x00000001; busy_o never drops early.
- 0x1234 x 0: stall_o only in the accept cycle -> done_o next cycle, result_o=0. Then 7 x 0x80000000 -> result_o=0x80000000 after 32 RUN cycles.
- Back-to-back: 6x7, then start_i held high through DONE with new operands 2x2 -> first done_o with result_o=42; the second op is accepted only in the following IDLE cycle; second done_o with result_o=4.
- Flush mid-RUN: 0xFF x 0xFF, flush_i in the 3rd RUN cycle -> IDLE next cycle, no done_o pulse, stall_o low the same cycle; a following 2x3 completes with result_o=6.
- Reset mid-RUN: rst_i high for 1 cycle in RUN -> state IDLE, result_o=0, all outputs 0. A start_i held during the reset cycle is not accepted.
